// File: rtl/prog_loader_if.sv
// Load-stream, processor bus and memory port bundle for prog_loader.
// slave = loader side, master = surrounding system / testbench side.
interface prog_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        reload;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic [15:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_enable;
  logic        cpu_resetn;
  logic        loading;

  modport slave (
    input  s_valid, s_data, reload, cpu_address, cpu_wr_data, cpu_wr_enable,
    output s_ready, mem_address, mem_wr_data, mem_wr_enable, cpu_resetn, loading
  );
  modport master (
    output s_valid, s_data, reload, cpu_address, cpu_wr_data, cpu_wr_enable,
    input  s_ready, mem_address, mem_wr_data, mem_wr_enable, cpu_resetn, loading
  );
endinterface

// File: rtl/prog_loader.sv
// Boot image loader: parses {base, length, data} from a byte stream into memory, then releases the CPU.
// Define PROG_LOADER_VECTOR_PATCH_EN to also write base into the reset vector (FFFC/FFFD) after the image.
module prog_loader (
  input  logic          clk,
  input  logic          resetn,
  prog_loader_if.slave  bus
);
`ifdef PROG_LOADER_VECTOR_PATCH_EN
  typedef enum logic [2:0] {HDR_LO, HDR_HI, LEN_LO, LEN_HI, DATA, VEC_LO, VEC_HI, RUN} state_t;
  localparam state_t DONE = VEC_LO;
`else
  typedef enum logic [2:0] {HDR_LO, HDR_HI, LEN_LO, LEN_HI, DATA, RUN} state_t;
  localparam state_t DONE = RUN;
`endif

  state_t      state, nxt;
  logic [15:0] base, ptr, cnt;
  logic [7:0]  len_lo;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        cpu_rst_q;
  logic        ready;
  logic        accept;
  logic        run;

  assign accept = bus.s_valid & ready;
  assign run    = (state == RUN);

  always_ff @(posedge clk) begin
    if (!resetn) state <= HDR_LO;
    else         state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ready = 1'b0;
    case (state)
      HDR_LO: begin ready = 1'b1; if (bus.s_valid) nxt = HDR_HI; end
      HDR_HI: begin ready = 1'b1; if (bus.s_valid) nxt = LEN_LO; end
      LEN_LO: begin ready = 1'b1; if (bus.s_valid) nxt = LEN_HI; end
      LEN_HI: begin
        ready = 1'b1;
        if (bus.s_valid) nxt = ({bus.s_data, len_lo} == 16'h0000) ? DONE : DATA;
      end
      DATA: begin
        ready = 1'b1;
        if (bus.s_valid && cnt == 16'h0001) nxt = DONE;
      end
`ifdef PROG_LOADER_VECTOR_PATCH_EN
      VEC_LO: nxt = VEC_HI;
      VEC_HI: nxt = RUN;
`endif
      RUN:     if (bus.reload) nxt = HDR_LO;
      default: nxt = HDR_LO;
    endcase
  end

  // Every loader write is registered, so it appears the cycle after the byte (or vector step) that produced it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base      <= '0;
      ptr       <= '0;
      cnt       <= '0;
      len_lo    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      cpu_rst_q <= (nxt == RUN);
      case (state)
        HDR_LO: if (accept) base[7:0]  <= bus.s_data;
        HDR_HI: if (accept) base[15:8] <= bus.s_data;
        LEN_LO: if (accept) len_lo     <= bus.s_data;
        LEN_HI: if (accept) begin
          ptr <= base;
          cnt <= {bus.s_data, len_lo};
        end
        DATA: if (accept) begin
          wr_addr <= ptr;
          wr_data <= bus.s_data;
          wr_en   <= 1'b1;
          ptr     <= ptr + 16'h0001;
          cnt     <= cnt - 16'h0001;
        end
`ifdef PROG_LOADER_VECTOR_PATCH_EN
        VEC_LO: begin
          wr_addr <= 16'hFFFC;
          wr_data <= base[7:0];
          wr_en   <= 1'b1;
        end
        VEC_HI: begin
          wr_addr <= 16'hFFFD;
          wr_data <= base[15:8];
          wr_en   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // The final loader write lands in the first RUN cycle; it owns the port for that one cycle.
  assign bus.mem_address   = (run && !wr_en) ? bus.cpu_address   : wr_addr;
  assign bus.mem_wr_data   = (run && !wr_en) ? bus.cpu_wr_data   : wr_data;
  assign bus.mem_wr_enable = (run && !wr_en) ? bus.cpu_wr_enable : wr_en;
  assign bus.s_ready       = ready;
  assign bus.loading       = !run;
  assign bus.cpu_resetn    = cpu_rst_q;
endmodule
